// File: rtl/d_ff_guard_pkg.sv
// Shared types and constants for the guarded multi-channel register bank.
// Optional parity output is enabled by defining D_FF_GUARD_PARITY_EN.
package d_ff_guard_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    SETTLE   = 2'd1,
    ARMED    = 2'd2
  } guard_state_t;

  localparam int REJ_CNT_W = 16;
  localparam logic [REJ_CNT_W-1:0] REJ_CNT_MAX = '1;

endpackage

// File: rtl/d_ff_guard_arm.sv
// Enable-key arming logic: samples en, flags key changes and only arms after the
// key has been stable for STABLE_CYC edges. Unaffected by D_FF_GUARD_PARITY_EN.
module d_ff_guard_arm
  import d_ff_guard_pkg::*;
#(
  parameter int              EN_W       = 5,
  parameter logic [EN_W-1:0] EN_KEY     = '1,
  parameter int              STABLE_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EN_W-1:0] en,
  output logic            is_diff,
  output logic            armed,
  output logic            acc_ok
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic [EN_W-1:0] en_q, en_d;
  logic            is_diff_q, is_diff_d;
  guard_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            key_match;

  assign key_match = (en == EN_KEY);

  always_comb begin
    en_d      = en;
    is_diff_d = (en != en_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      is_diff_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      is_diff_q <= is_diff_d;
    end
  end

  // Any edge with en off-key drops straight back to DISARMED and clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DISARMED;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (key_match) begin
            if (STABLE_CYC == 1) begin
              state_q <= ARMED;
            end else begin
              state_q <= SETTLE;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        SETTLE: begin
          if (!key_match) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ARMED;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ARMED: begin
          if (!key_match) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= DISARMED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign is_diff = is_diff_q;
  assign armed   = (state_q == ARMED);
  // Writes need the pre-edge ARMED state and the key still present on this edge.
  assign acc_ok  = (state_q == ARMED) && key_match;

endmodule

// File: rtl/d_ff_guard_bank.sv
// Multi-channel data register bank whose writes are gated by a stable enable key.
// Define D_FF_GUARD_PARITY_EN to add the per-channel q_par output.
module d_ff_guard_bank
  import d_ff_guard_pkg::*;
#(
  parameter int              DATA_W     = 1,
  parameter int              CH         = 4,
  parameter int              EN_W       = 5,
  parameter logic [EN_W-1:0] EN_KEY     = '1,
  parameter int              STABLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH*DATA_W-1:0] d,
  input  logic [CH-1:0]        ch_we,
  input  logic [EN_W-1:0]      en,
  output logic [CH*DATA_W-1:0] q,
  output logic                 is_diff,
  output logic                 armed,
  output logic [CH-1:0]        upd,
  output logic [REJ_CNT_W-1:0] rej_cnt
`ifdef D_FF_GUARD_PARITY_EN
  ,
  output logic [CH-1:0]        q_par
`endif
);

  localparam int POP_W = $clog2(CH + 1);
  localparam int SUM_W = REJ_CNT_W + 1;

  function automatic logic [REJ_CNT_W-1:0] sat_add(input logic [REJ_CNT_W-1:0] a,
                                                    input logic [POP_W-1:0]     b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(b);
    return s[REJ_CNT_W] ? REJ_CNT_MAX : s[REJ_CNT_W-1:0];
  endfunction

  logic                 acc_ok;
  logic [CH*DATA_W-1:0] q_q, q_d;
  logic [CH-1:0]        upd_q, upd_d;
  logic [REJ_CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic [POP_W-1:0]     rej_pop;

  d_ff_guard_arm #(
    .EN_W       (EN_W),
    .EN_KEY     (EN_KEY),
    .STABLE_CYC (STABLE_CYC)
  ) u_arm (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .is_diff (is_diff),
    .armed   (armed),
    .acc_ok  (acc_ok)
  );

  // Each channel is judged independently against the shared acceptance qualifier.
  always_comb begin
    q_d     = q_q;
    upd_d   = '0;
    rej_pop = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch_we[i]) begin
        if (acc_ok) begin
          q_d[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
          upd_d[i]                = 1'b1;
        end else begin
          rej_pop = rej_pop + POP_W'(1);
        end
      end
    end
    rej_cnt_d = sat_add(rej_cnt_q, rej_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= '0;
      upd_q     <= '0;
      rej_cnt_q <= '0;
    end else begin
      q_q       <= q_d;
      upd_q     <= upd_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign q       = q_q;
  assign upd     = upd_q;
  assign rej_cnt = rej_cnt_q;

`ifdef D_FF_GUARD_PARITY_EN
  logic [CH-1:0] q_par_q, q_par_d;

  // Parity follows the next data value so it lands on the same edge as q.
  always_comb begin
    q_par_d = '0;
    for (int i = 0; i < CH; i++) begin
      q_par_d[i] = ^q_d[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_par_q <= '0;
    end else begin
      q_par_q <= q_par_d;
    end
  end

  assign q_par = q_par_q;
`endif

endmodule

// File: tb/tb_d_ff_guard_bank.sv
// Randomized self-checking bench for d_ff_guard_bank against a key-history model.
// Covers D_FF_GUARD_PARITY_EN when the macro is defined for the build.
module tb_d_ff_guard_bank;

  localparam int         DW  = 1;
  localparam int         NCH = 4;
  localparam int         ENW = 5;
  localparam logic [4:0] KEY = 5'h1f;
  localparam int         STB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  d, ch_we;
  logic [4:0]  en;
  logic [3:0]  q, upd;
  logic        is_diff, armed;
  logic [15:0] rej_cnt;

  logic [15:0] d2;
  logic [1:0]  we2;
  logic [4:0]  en2;
  logic [15:0] q2;
  logic [1:0]  upd2;
  logic        isd2, arm2;
  logic [15:0] rej2;
`ifdef D_FF_GUARD_PARITY_EN
  logic [3:0]  q_par;
  logic [1:0]  qpar2;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  int          run;
  logic [4:0]  prev_en;
  logic [3:0]  mq, mupd;
  logic        mdiff;
  int          mrej;

  always #5 clk = ~clk;

  d_ff_guard_bank #(.DATA_W(DW), .CH(NCH), .EN_W(ENW), .EN_KEY(KEY), .STABLE_CYC(STB)) dut (
    .clk(clk), .reset(reset), .d(d), .ch_we(ch_we), .en(en), .q(q),
    .is_diff(is_diff), .armed(armed), .upd(upd), .rej_cnt(rej_cnt)
`ifdef D_FF_GUARD_PARITY_EN
    , .q_par(q_par)
`endif
  );

  d_ff_guard_bank #(.DATA_W(8), .CH(2), .EN_W(5), .EN_KEY(5'h1f), .STABLE_CYC(1)) dut2 (
    .clk(clk), .reset(reset), .d(d2), .ch_we(we2), .en(en2), .q(q2),
    .is_diff(isd2), .armed(arm2), .upd(upd2), .rej_cnt(rej2)
`ifdef D_FF_GUARD_PARITY_EN
    , .q_par(qpar2)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; prev_en = '0; mq = '0; mupd = '0; mdiff = 1'b0; mrej = 0;
  endtask

  // Writes land only if the key was seen on STB consecutive earlier edges and is still present.
  task automatic model_edge();
    int   rj;
    logic ok;
    ok = (run >= STB) && (en == KEY);
    rj = 0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_we[i] && ok) begin
        mq[i*DW +: DW] = d[i*DW +: DW];
        mupd[i] = 1'b1;
      end else begin
        mupd[i] = 1'b0;
        if (ch_we[i]) rj++;
      end
    end
    mrej    = (mrej + rj > 65535) ? 65535 : mrej + rj;
    mdiff   = (en != prev_en);
    prev_en = en;
    run     = (en == KEY) ? ((run < 1000) ? run + 1 : run) : 0;
  endtask

  task automatic check_outputs();
    check_eq("q", 32'(q), 32'(mq));
    check_eq("upd", 32'(upd), 32'(mupd));
    check_eq("is_diff", 32'(is_diff), 32'(mdiff));
    check_eq("armed", 32'(armed), (run >= STB) ? 32'd1 : 32'd0);
    check_eq("rej_cnt", 32'(rej_cnt), 32'(mrej));
`ifdef D_FF_GUARD_PARITY_EN
    begin
      logic [3:0] mp;
      for (int i = 0; i < NCH; i++) mp[i] = ^mq[i*DW +: DW];
      check_eq("q_par", 32'(q_par), 32'(mp));
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_q"}, 32'(q), 32'd0);
    check_eq({tag, "_upd"}, 32'(upd), 32'd0);
    check_eq({tag, "_diff"}, 32'(is_diff), 32'd0);
    check_eq({tag, "_armed"}, 32'(armed), 32'd0);
    check_eq({tag, "_rej"}, 32'(rej_cnt), 32'd0);
    check_eq({tag, "_q2"}, 32'(q2), 32'd0);
    check_eq({tag, "_arm2"}, 32'(arm2), 32'd0);
  endtask

  // Called at posedge+1: asserts reset between edges and checks outputs clear before any edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    d = '0; ch_we = '0; en = '0;
    d2 = '0; we2 = '0; en2 = '0;
    model_reset();
    #3 check_zero("por");
    @(posedge clk);
    #2 reset = 1'b0;

    // rejected writes while disarmed
    en = 5'h00; ch_we = 4'b1111; d = 4'b1010;
    repeat (3) step();
    check_eq("rej12", 32'(rej_cnt), 32'd12);

    // arm and write
    en = KEY; ch_we = '0;
    repeat (2) step();
    check_eq("armed_after2", 32'(armed), 32'd1);
    d = 4'b0110; ch_we = 4'b0110;
    step();
    check_eq("wr_q", 32'(q), 32'h6);
    check_eq("wr_upd", 32'(upd), 32'h6);
    ch_we = '0;
    step();
    check_eq("upd_pulse", 32'(upd), 32'h0);

    // key drop on the same edge as a write
    en = 5'h1e; ch_we = 4'b0001; d = 4'b0001;
    step();
    check_eq("drop_armed", 32'(armed), 32'd0);
    check_eq("drop_diff", 32'(is_diff), 32'd1);
    en = KEY; ch_we = '0;
    repeat (3) step();
    check_eq("rearm", 32'(armed), 32'd1);

    // alternating key never arms
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0) ? 5'h1e : 5'h1f;
      ch_we = 4'($urandom); d = 4'($urandom);
      step();
    end

    // mostly-stable key with random glitches
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 5) == 0) ? 5'($urandom) : KEY;
      ch_we = 4'($urandom); d = 4'($urandom);
      step();
    end

    // reset mid-SETTLE, then re-arm
    en = 5'h00; ch_we = '0;
    step();
    en = KEY;
    step();
    async_reset("rst_settle");
    en = KEY; ch_we = '0;
    step();
    check_eq("post_rst_1", 32'(armed), 32'd0);
    step();
    check_eq("post_rst_2", 32'(armed), 32'd1);

    // reset with a write pending
    ch_we = 4'b1111; d = 4'b1111;
    step();
    ch_we = 4'b0101; d = 4'b0000;
    async_reset("rst_write");

    // saturate the reject counter
    en = 5'h00; ch_we = 4'b1111;
    repeat (17600) step();
    check_eq("rej_sat", 32'(rej_cnt), 32'hffff);
    ch_we = '0;

    // single-cycle settle, wide channels
    async_reset("rst_dut2");
    en2 = 5'h1f;
    step();
    check_eq("d2_armed", 32'(arm2), 32'd1);
    d2 = 16'h0700; we2 = 2'b10;
    step();
    check_eq("d2_q", 32'(q2), 32'h0700);
    check_eq("d2_upd", 32'(upd2), 32'h2);
    check_eq("d2_rej", 32'(rej2), 32'd0);
`ifdef D_FF_GUARD_PARITY_EN
    check_eq("d2_par", 32'(qpar2), 32'h2);
`endif
    we2 = '0;
    step();
    check_eq("d2_upd_off", 32'(upd2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
